chaos_wb_bridge: RTL
====================

# chaos_wb_bridge

Wishbone slave that lets the management SoC configure and read back the chaos automaton array. It decodes a small register window at BASE_ADR, drives the array's hold, wdata and write inputs, and captures rdata from the array. A counted shift engine issues write pulses to the array's configuration chain. The block sits between the user-area Wishbone port and chaos_array inside user_project_wrapper.

## Interface
- BASE_ADR, 32'h3000_0000: register window base; decode on wbs_adr_i[31:8].
- CNT_W, 12: shift-count width; must cover XSIZE*YSIZE = 1500.

- wb_clk_i  in  1  single clock for all logic
- wb_rst_i  in  1  asynchronous, active-high reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write
- wbs_sel_i  in  4  byte selects, honoured on all writable fields
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data
- wbs_ack_o  out  1  registered single-cycle acknowledge
- wbs_dat_o  out  32  read data, valid with ack, 0 otherwise
- hold  out  1  freezes array evolution; required for shifting
- wdata  out  64  data presented to the configuration chain
- write  out  1  one-cycle shift pulse to the array
- rdata  in  64  chain output from the array
- irq  out  1  DONE & IE, level

## Operation
- Registers are word offsets via wbs_adr_i[7:2]:
  - 0x00 CTRL, rw: bit0 HOLD (reset 1), bit1 IE (reset 0).
  - 0x04 STATUS: bit0 BUSY (ro); bit1 DONE (w1c); bit2 ERR (w1c); [16+CNT_W-1:16] remaining count (ro).
  - 0x08 WDATA_LO and 0x0C WDATA_HI, rw, drive wdata[31:0] and wdata[63:32].
  - 0x10 RDATA_LO and 0x14 RDATA_HI, ro, return the captured rdata.
  - 0x18 SHIFT: a write loads count[CNT_W-1:0] and starts the engine; a read returns the last count written.
  - Other in-window offsets ack, read 0, and ignore writes.
- A write to WDATA_HI starts one shift (count 1), after the data update.
- The state machine has three states: IDLE, PULSE, CAPTURE.
  - IDLE: on a start with count N>0 and HOLD=1, load cnt=N and go to PULSE. N=0 is a no-op with no flags set.
  - PULSE: write=1 for exactly one cycle, then go to CAPTURE.
  - CAPTURE: write=0, rdata_q<=rdata, cnt<=cnt-1. If cnt==1, go to IDLE and set DONE; otherwise go to PULSE.
- BUSY equals (state != IDLE).
- The following requests set ERR and are otherwise dropped:
  - a start while HOLD=0;
  - a write to WDATA_*, SHIFT or CTRL.HOLD while BUSY. CTRL.IE still updates in this case.
- All such writes are still acked.
- The count register and cnt saturate at no values; they are plain CNT_W-bit fields, and upper bits of wbs_dat_i are ignored.
- When a w1c clear and a set of DONE or ERR occur on the same edge, the set wins.
- Addresses outside the window get no ack and do not affect state.

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, hold=1, wdata=0, write=0, irq=0, rdata_q=0, state IDLE, cnt=0.
- Reset is asynchronous. Asserting it mid-shift immediately deasserts write and returns everything to its reset value.
- Acknowledge:
  - A request (stb & cyc & window hit & !wbs_ack_o) sampled at edge T gives wbs_ack_o=1 for the cycle T..T+1 only.
  - Back-to-back requests therefore ack every other cycle.
- Register writes take effect at edge T.
- A start sampled at edge T gives:
  - write high during T..T+1;
  - capture at edge T+2;
  - for N shifts, BUSY high for 2N cycles;
  - DONE and BUSY=0 visible from edge T+2N.
- wdata is stable throughout a shift sequence, because writes to it are blocked while BUSY.
- irq follows DONE/IE combinationally from the registered values.

## Test plan
- Reset: assert wb_rst_i asynchronously mid-cycle -> hold=1, write=0, ack=0. STATUS reads 0 and CTRL reads 0x1.
- Single shift:
  - Stimulus: write WDATA_LO=0xDEADBEEF, then WDATA_HI=0x01234567.
  - Required: wdata=0x01234567DEADBEEF, one write pulse, BUSY for 2 cycles, DONE=1.
  - Required: RDATA_HI/LO equal the modelled rdata at capture.
- Bulk shift:
  - Stimulus: SHIFT=1500 with IE=1.
  - Required: exactly 1500 write pulses, 2 cycles apart; remaining count decreasing in STATUS.
  - Required: irq=1 after 3000 cycles; writing 0x2 to STATUS clears DONE and irq.
- Errors:
  - SHIFT=5 with HOLD=0 -> no pulse, ERR=1.
  - WDATA_LO write during BUSY -> wdata unchanged, ERR=1, ack still returned.
- Decode:
  - Access to 0x3000_0100 -> no ack.
  - Read of 0x3000_001C -> ack with 0.
  - sel=4'b0001 write to WDATA_LO=0xFFFFFFFF -> only byte 0 changes.
- Reset during shift: assert reset in the middle of SHIFT=10 -> write drops immediately and no further pulses follow.

Source files
------------

// File: rtl/chaos_wb_bridge.sv
// chaos_wb_bridge: Wishbone register window that configures and reads back
// the chaos automaton array through its serial configuration chain.
module chaos_wb_bridge #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          CNT_W    = 12
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        hold,
  output logic [63:0] wdata,
  output logic        write,
  input  logic [63:0] rdata,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam logic [5:0] OFS_CTRL   = 6'h00;
  localparam logic [5:0] OFS_STATUS = 6'h01;
  localparam logic [5:0] OFS_WLO    = 6'h02;
  localparam logic [5:0] OFS_WHI    = 6'h03;
  localparam logic [5:0] OFS_RLO    = 6'h04;
  localparam logic [5:0] OFS_RHI    = 6'h05;
  localparam logic [5:0] OFS_SHIFT  = 6'h06;

  logic             ack_q;
  logic [31:0]      dat_q;
  logic             hold_q, ie_q, done_q, err_q;
  logic [63:0]      wdata_q, rdata_q;
  logic [CNT_W-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;

  logic             req, wr, busy;
  logic [5:0]       ofs;
  logic [31:0]      sel_mask, shift_m, rd_val;
  logic             start_req, start, err_set, done_set, capture;
  logic [CNT_W-1:0] start_cnt;
  logic             unused_ok;

  assign req  = wbs_stb_i & wbs_cyc_i & ~ack_q & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign wr   = req & wbs_we_i;
  assign ofs  = wbs_adr_i[7:2];
  assign busy = (state_q != ST_IDLE);

  assign sel_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign shift_m  = (32'(shift_q) & ~sel_mask) | (wbs_dat_i & sel_mask);

  assign unused_ok = &{1'b0, wbs_adr_i[1:0], shift_m[31:CNT_W]};

  // Decode writes into start requests and error events.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    start_req = 1'b0;
    start_cnt = '0;
    err_set   = 1'b0;
    if (wr) begin
      case (ofs)
        OFS_CTRL:  if (busy && wbs_sel_i[0]) err_set = 1'b1;
        OFS_WLO:   if (busy) err_set = 1'b1;
        OFS_WHI:   if (busy) err_set = 1'b1;
                   else begin start_req = 1'b1; start_cnt = CNT_W'(1); end
        OFS_SHIFT: if (busy) err_set = 1'b1;
                   else begin start_req = 1'b1; start_cnt = shift_m[CNT_W-1:0]; end
        default: ;
      endcase
    end
    // A zero count is a silent no-op; a real start without HOLD is an error.
    start = start_req && (start_cnt != '0) && hold_q;
    if (start_req && (start_cnt != '0) && !hold_q) err_set = 1'b1;
  end

  // Read mux for the register window; unmapped offsets read zero.
  always_comb begin
    rd_val = 32'h0;
    case (ofs)
      OFS_CTRL:   rd_val = {30'd0, ie_q, hold_q};
      OFS_STATUS: rd_val = (32'(cnt_q) << 16) | {29'd0, err_q, done_q, busy};
      OFS_WLO:    rd_val = wdata_q[31:0];
      OFS_WHI:    rd_val = wdata_q[63:32];
      OFS_RLO:    rd_val = rdata_q[31:0];
      OFS_RHI:    rd_val = rdata_q[63:32];
      OFS_SHIFT:  rd_val = 32'(shift_q);
      default:    rd_val = 32'h0;
    endcase
  end

  // Shift engine next state: one pulse cycle then one capture cycle per shift.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    done_set = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin cnt_d = start_cnt; state_d = ST_PULSE; end
      ST_PULSE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        capture = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_IDLE;
          done_set = 1'b1;
        end else begin
          state_d = ST_PULSE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Wishbone acknowledge and registered read data, zero outside the ack cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= 32'h0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wbs_we_i) ? rd_val : 32'h0;
    end
  end

  // Control, data and sticky status registers; a flag set beats a w1c clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hold_q  <= 1'b1;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 64'h0;
      shift_q <= '0;
    end else begin
      if (wr && ofs == OFS_CTRL && wbs_sel_i[0]) begin
        ie_q <= wbs_dat_i[1];
        if (!busy) hold_q <= wbs_dat_i[0];
      end
      if (wr && !busy) begin
        if (ofs == OFS_WLO)
          wdata_q[31:0]  <= (wdata_q[31:0] & ~sel_mask) | (wbs_dat_i & sel_mask);
        if (ofs == OFS_WHI)
          wdata_q[63:32] <= (wdata_q[63:32] & ~sel_mask) | (wbs_dat_i & sel_mask);
        if (ofs == OFS_SHIFT)
          shift_q <= shift_m[CNT_W-1:0];
      end
      if (done_set)
        done_q <= 1'b1;
      else if (wr && ofs == OFS_STATUS && wbs_sel_i[0] && wbs_dat_i[1])
        done_q <= 1'b0;
      if (err_set)
        err_q <= 1'b1;
      else if (wr && ofs == OFS_STATUS && wbs_sel_i[0] && wbs_dat_i[2])
        err_q <= 1'b0;
    end
  end

  // Shift engine state, remaining count and captured chain output.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= 64'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) rdata_q <= rdata;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign hold      = hold_q;
  assign wdata     = wdata_q;
  assign write     = (state_q == ST_PULSE);
  assign irq       = done_q & ie_q;

endmodule
